// File: rtl/spike_window_discriminator_if.sv
// Sample-stream and event-result bundle for one discriminator channel.
// The master (HPF side / bench) drives samples, and the slave (discriminator)
// reports its decisions and status.
interface spike_window_discriminator_if #(
  parameter int DATA_W = 16,
  parameter int N_WIN  = 8,
  parameter int CNT_W  = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              detect;
  logic              reject;
  logic              busy;
  logic [2:0]        fsm_state;
  logic [N_WIN-1:0]  win_state;
  logic [CNT_W-1:0]  sample_cnt;

  modport master (
    output sample_valid, sample_in,
    input  detect, reject, busy, fsm_state, win_state, sample_cnt
  );

  modport slave (
    input  sample_valid, sample_in,
    output detect, reject, busy, fsm_state, win_state, sample_cnt
  );
endinterface

// File: rtl/spike_window_discriminator.sv
// Spike window discriminator: this block arms on a threshold crossing of an
// offset-binary sample stream. It then checks N_WIN inclusion/exclusion time
// windows against the samples that follow. It issues a one-cycle detect or
// reject pulse per event, followed by a refractory period.
module spike_window_discriminator #(
  parameter int DATA_W = 16,
  parameter int N_WIN  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    dataclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_W-1:0]       thrsh,
  input  logic                    thrsh_pol,
  input  logic [N_WIN-1:0]        win_en,
  input  logic [N_WIN-1:0]        win_edge_type,
  input  logic [N_WIN*CNT_W-1:0]  win_start,
  input  logic [N_WIN*CNT_W-1:0]  win_stop,
  input  logic [N_WIN*DATA_W-1:0] win_level,
  input  logic [CNT_W-1:0]        stop_max,
  input  logic [CNT_W-1:0]        refract,
  spike_window_discriminator_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_TRACK   = 3'd2,
    S_REFRACT = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Unsigned compare; equality never counts as beyond.
  function automatic logic beyond(input logic [DATA_W-1:0] x,
                                  input logic [DATA_W-1:0] lvl,
                                  input logic              pol);
    return pol ? (x > lvl) : (x < lvl);
  endfunction

  state_t                  state;
  logic                    prev_beyond;
  logic [CNT_W-1:0]        sample_cnt;
  logic [CNT_W-1:0]        ref_cnt;
  logic [N_WIN-1:0]        win_state;
  logic                    detect;
  logic                    reject;

  // Event configuration, frozen at the crossing so mid-event edits are ignored
  logic [N_WIN-1:0]        sh_en;
  logic [N_WIN-1:0]        sh_edge;
  logic [N_WIN*CNT_W-1:0]  sh_start;
  logic [N_WIN*CNT_W-1:0]  sh_stop;
  logic [N_WIN*DATA_W-1:0] sh_level;
  logic [CNT_W-1:0]        sh_stop_max;
  logic [CNT_W-1:0]        sh_refract;
  logic                    sh_pol;

  // Configuration actually used for window evaluation this cycle
  logic [N_WIN-1:0]        e_en;
  logic [N_WIN-1:0]        e_edge;
  logic [N_WIN*CNT_W-1:0]  e_start;
  logic [N_WIN*CNT_W-1:0]  e_stop;
  logic [N_WIN*DATA_W-1:0] e_level;
  logic [CNT_W-1:0]        e_stop_max;
  logic                    e_pol;

  logic                    thr_beyond;
  logic                    crossing;
  logic [CNT_W-1:0]        eval_cnt;
  logic [N_WIN-1:0]        ws_next;
  logic                    abort;
  logic                    at_end;
  logic                    all_ok;

  assign thr_beyond = beyond(sif.sample_in, thrsh, thrsh_pol);
  assign crossing   = (state == S_ARMED) && sif.sample_valid && thr_beyond && !prev_beyond;

  // The crossing sample is evaluated before the shadows load, so it sees live config
  always_comb begin
    if (state == S_ARMED) begin
      e_en       = win_en;
      e_edge     = win_edge_type;
      e_start    = win_start;
      e_stop     = win_stop;
      e_level    = win_level;
      e_stop_max = stop_max;
      e_pol      = thrsh_pol;
    end else begin
      e_en       = sh_en;
      e_edge     = sh_edge;
      e_start    = sh_start;
      e_stop     = sh_stop;
      e_level    = sh_level;
      e_stop_max = sh_stop_max;
      e_pol      = sh_pol;
    end
  end

  // Window hit evaluation for the current valid sample at count eval_cnt
  always_comb begin
    eval_cnt = (state == S_TRACK) ? sample_cnt + CNT_ONE : '0;
    ws_next  = (state == S_ARMED) ? (e_en & e_edge) : win_state;
    abort    = 1'b0;
    for (int i = 0; i < N_WIN; i++) begin
      if (e_en[i] &&
          (e_start[i*CNT_W +: CNT_W] <= eval_cnt) &&
          (eval_cnt <= e_stop[i*CNT_W +: CNT_W]) &&
          beyond(sif.sample_in, e_level[i*DATA_W +: DATA_W], e_pol)) begin
        if (e_edge[i]) begin
          ws_next[i] = 1'b0;
          abort      = 1'b1;
        end else begin
          ws_next[i] = 1'b1;
        end
      end
    end
    all_ok = &(ws_next | ~e_en);
    at_end = (eval_cnt == e_stop_max);
  end

  // Shadow capture on the arming crossing
  always_ff @(posedge dataclk) begin
    if (enable && crossing) begin
      sh_en       <= win_en;
      sh_edge     <= win_edge_type;
      sh_start    <= win_start;
      sh_stop     <= win_stop;
      sh_level    <= win_level;
      sh_stop_max <= stop_max;
      sh_refract  <= refract;
      sh_pol      <= thrsh_pol;
    end
  end

  // Event FSM with registered pulses, counters and window flags
  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      prev_beyond <= 1'b1;
      sample_cnt  <= '0;
      ref_cnt     <= '0;
      win_state   <= '0;
      detect      <= 1'b0;
      reject      <= 1'b0;
    end else begin
      detect <= 1'b0;
      reject <= 1'b0;
      if (!enable) begin
        state      <= S_IDLE;
        sample_cnt <= '0;
        ref_cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state       <= S_ARMED;
            prev_beyond <= 1'b1;
          end
          S_ARMED, S_TRACK: begin
            if (sif.sample_valid) begin
              prev_beyond <= thr_beyond;
              if (state == S_TRACK || crossing) begin
                sample_cnt <= eval_cnt;
                win_state  <= ws_next;
                ref_cnt    <= '0;
                if (abort) begin
                  reject <= 1'b1;
                  state  <= S_REFRACT;
                end else if (at_end) begin
                  detect <= all_ok;
                  reject <= !all_ok;
                  state  <= S_REFRACT;
                end else begin
                  state  <= S_TRACK;
                end
              end
            end
          end
          S_REFRACT: begin
            if (sif.sample_valid) prev_beyond <= thr_beyond;
            if (sh_refract == '0) begin
              state <= S_ARMED;
            end else if (sif.sample_valid) begin
              ref_cnt <= ref_cnt + CNT_ONE;
              if (ref_cnt + CNT_ONE == sh_refract) state <= S_ARMED;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign sif.detect     = detect;
  assign sif.reject     = reject;
  assign sif.busy       = (state == S_TRACK) || (state == S_REFRACT);
  assign sif.fsm_state  = state;
  assign sif.win_state  = win_state;
  assign sif.sample_cnt = sample_cnt;

endmodule

// File: tb/tb_spike_window_discriminator.sv
// Bench for spike_window_discriminator (4 windows): directed event scenarios
// followed by randomized streams and configurations, all compared every cycle
// against a sample-by-sample behavioural model of the discriminator rules.
module tb_spike_window_discriminator;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int CW = 16;

  logic           dataclk;
  logic           reset;
  logic           enable;
  logic [DW-1:0]  thrsh;
  logic           thrsh_pol;
  logic [NW-1:0]  win_en;
  logic [NW-1:0]  win_edge_type;
  logic [NW*CW-1:0] win_start;
  logic [NW*CW-1:0] win_stop;
  logic [NW*DW-1:0] win_level;
  logic [CW-1:0]  stop_max;
  logic [CW-1:0]  refract;

  spike_window_discriminator_if #(.DATA_W(DW), .N_WIN(NW), .CNT_W(CW)) sif ();

  spike_window_discriminator #(.DATA_W(DW), .N_WIN(NW), .CNT_W(CW)) dut (
    .dataclk       (dataclk),
    .reset         (reset),
    .enable        (enable),
    .thrsh         (thrsh),
    .thrsh_pol     (thrsh_pol),
    .win_en        (win_en),
    .win_edge_type (win_edge_type),
    .win_start     (win_start),
    .win_stop      (win_stop),
    .win_level     (win_level),
    .stop_max      (stop_max),
    .refract       (refract),
    .sif           (sif)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // mode: 0 idle, 1 armed, 2 tracking, 3 refractory
  int          m_mode, m_cnt, m_rcnt;
  bit          m_prev, m_det, m_rej;
  bit [NW-1:0] m_ws;
  bit [NW-1:0] s_en, s_edge;
  bit [NW*CW-1:0] s_start, s_stop;
  bit [NW*DW-1:0] s_level;
  int          s_stop_max, s_refract;
  bit          s_pol;

  function automatic bit bey(int unsigned x, int unsigned l, bit pol);
    return pol ? (x > l) : (x < l);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cnt = 0; m_rcnt = 0; m_prev = 1;
    m_det = 0; m_rej = 0; m_ws = '0;
  endtask

  // Apply one sample at count c; end the event on an exclusion hit or at stop_max
  task automatic m_eval(int c, int unsigned x);
    bit hit_excl = 0;
    bit ok = 1;
    for (int i = 0; i < NW; i++) begin
      int st = int'(s_start[i*CW +: CW]);
      int sp = int'(s_stop[i*CW +: CW]);
      if (s_en[i] && c >= st && c <= sp && bey(x, s_level[i*DW +: DW], s_pol)) begin
        if (s_edge[i]) begin m_ws[i] = 0; hit_excl = 1; end
        else m_ws[i] = 1;
      end
    end
    for (int i = 0; i < NW; i++) if (s_en[i] && !m_ws[i]) ok = 0;
    if (hit_excl) begin
      m_rej = 1; m_mode = 3; m_rcnt = 0;
    end else if (c == s_stop_max) begin
      m_det = ok; m_rej = !ok; m_mode = 3; m_rcnt = 0;
    end else begin
      m_mode = 2;
    end
  endtask

  task automatic m_step(bit en, bit v, int unsigned x);
    bit b;
    b = bey(x, thrsh, thrsh_pol);
    m_det = 0; m_rej = 0;
    if (!en) begin
      m_mode = 0; m_cnt = 0; m_rcnt = 0;
      return;
    end
    case (m_mode)
      0: begin m_mode = 1; m_prev = 1; end
      1: if (v) begin
        if (b && !m_prev) begin
          s_en = win_en; s_edge = win_edge_type; s_start = win_start; s_stop = win_stop;
          s_level = win_level; s_stop_max = int'(stop_max); s_refract = int'(refract);
          s_pol = thrsh_pol;
          m_cnt = 0;
          m_ws = win_en & win_edge_type;
          m_eval(0, x);
        end
        m_prev = b;
      end
      2: if (v) begin
        m_cnt = m_cnt + 1;
        m_eval(m_cnt, x);
        m_prev = b;
      end
      default: begin
        if (v) m_prev = b;
        if (s_refract == 0) m_mode = 1;
        else if (v) begin
          m_rcnt++;
          if (m_rcnt == s_refract) m_mode = 1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("fsm_state", sif.fsm_state, m_mode);
    chk("detect", sif.detect, m_det);
    chk("reject", sif.reject, m_rej);
    chk("sample_cnt", sif.sample_cnt, m_cnt);
    chk("win_state", sif.win_state, m_ws);
    chk("busy", sif.busy, (m_mode == 2 || m_mode == 3));
    if (sif.detect || sif.reject) n_pulse++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge dataclk);
    m_step(enable, sif.sample_valid, sif.sample_in);
    #1;
    compare_all();
  endtask

  task automatic samp(int unsigned x);
    sif.sample_valid = 1'b1;
    sif.sample_in    = x[DW-1:0];
    tick();
  endtask

  task automatic gap(int n);
    sif.sample_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    m_reset();
    chk("rst_fsm", sif.fsm_state, 0);
    chk("rst_det", sif.detect, 0);
    chk("rst_rej", sif.reject, 0);
    chk("rst_cnt", sif.sample_cnt, 0);
    chk("rst_ws", sif.win_state, 0);
    chk("rst_busy", sif.busy, 0);
    #3;
    reset = 1'b1;
  endtask

  task automatic cfg_base();
    thrsh         = 16'd31568;
    thrsh_pol     = 1'b0;
    win_en        = 4'b1111;
    win_edge_type = 4'b1100;
    win_start     = {16'd3, 16'd2, 16'd1, 16'd0};
    win_stop      = {16'd6, 16'd4, 16'd3, 16'd2};
    win_level     = {16'd28676, 16'd31599, 16'd31727, 16'd31568};
    stop_max      = 16'd7;
    refract       = 16'd2;
  endtask

  // Event that satisfies both inclusion windows: window 1 opens at count 1,
  // so the count-1 sample sits just below its level 31727.
  task automatic good_event();
    samp(31000);
    samp(31650);
  endtask

  int p0;

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    sif.sample_valid = 1'b0;
    sif.sample_in = 16'd32768;
    cfg_base();
    m_reset();
    #2;
    compare_all();
    #10;
    reset = 1'b1;

    // ---- case 1: full event ending in detect ----
    enable = 1'b1;
    gap(1);
    chk("c1_armed", sif.fsm_state, 1);
    p0 = n_pulse;
    samp(32768);
    good_event();
    for (int c = 2; c <= 7; c++) samp(32000);
    chk("c1_detect", sif.detect, 1);
    chk("c1_cnt", sif.sample_cnt, 7);
    chk("c1_ws", sif.win_state, 4'b1111);
    chk("c1_npulse", n_pulse - p0, 1);

    // ---- case 2: exclusion window 3 violated at count 4 ----
    repeat (3) samp(32768);
    good_event();
    samp(32000); samp(32000);
    samp(28000);
    chk("c2_reject", sif.reject, 1);
    chk("c2_nodet", sif.detect, 0);
    chk("c2_refract", sif.fsm_state, 3);
    repeat (3) samp(32768);

    // ---- case 3: stream already beyond threshold when enabled ----
    enable = 1'b0;
    gap(1);
    sif.sample_in = 16'd30000;
    enable = 1'b1;
    gap(1);
    p0 = n_pulse;
    repeat (10) samp(30000);
    chk("c3_notrig", sif.fsm_state, 1);
    samp(32768);
    samp(30000);
    chk("c3_trig", sif.fsm_state, 2);
    repeat (20) samp(30000);
    chk("c3_once", n_pulse - p0, 1);

    // ---- case 4: crossing inside the refractory period is ignored ----
    refract = 16'd5;
    samp(32768);
    samp(31000); samp(31650); samp(28000);
    chk("c4_reject", sif.reject, 1);
    samp(32768); samp(32768); samp(31000);
    chk("c4_ignored", sif.fsm_state, 3);
    samp(32768); samp(32768);
    chk("c4_rearmed", sif.fsm_state, 1);
    samp(31000);
    chk("c4_new_evt", sif.fsm_state, 2);
    chk("c4_cnt0", sif.sample_cnt, 0);

    // ---- case 5: mid-event config edits are ignored ----
    samp(31650);
    win_stop[0 +: CW] = 16'd0;
    stop_max = 16'd3;
    for (int c = 2; c <= 6; c++) samp(32000);
    chk("c5_nodet_early", n_pulse > 0 && sif.detect, 0);
    samp(32000);
    chk("c5_detect", sif.detect, 1);
    cfg_base();
    repeat (6) samp(32768);

    // ---- case 6: enable drop and reset mid-event, valid gaps ----
    p0 = n_pulse;
    good_event();
    samp(32000); samp(32000);
    enable = 1'b0;
    gap(1);
    chk("c6_idle", sif.fsm_state, 0);
    chk("c6_cnt", sif.sample_cnt, 0);
    chk("c6_busy", sif.busy, 0);
    enable = 1'b1;
    gap(1);
    samp(32768);
    good_event();
    gap(4);
    chk("c6_hold", sif.sample_cnt, 1);
    samp(32000); samp(32000);
    do_reset();
    gap(3);
    chk("c6_nopulse", n_pulse - p0, 0);

    // ---- randomized streams and configurations ----
    for (int ep = 0; ep < 60; ep++) begin
      thrsh     = 16'($urandom_range(30000, 35000));
      thrsh_pol = 1'($urandom_range(0, 1));
      win_en        = 4'($urandom_range(0, 15));
      win_edge_type = 4'($urandom_range(0, 15));
      for (int i = 0; i < NW; i++) begin
        win_start[i*CW +: CW] = 16'($urandom_range(0, 7));
        win_stop[i*CW +: CW]  = 16'($urandom_range(0, 9));
        win_level[i*DW +: DW] = 16'(int'(thrsh) + $urandom_range(0, 4000) - 2000);
      end
      stop_max = 16'($urandom_range(0, 10));
      refract  = 16'($urandom_range(0, 4));
      for (int k = 0; k < 40; k++) begin
        enable = ($urandom_range(0, 49) != 0);
        if ($urandom_range(0, 199) == 0) do_reset();
        sif.sample_valid = ($urandom_range(0, 3) != 0);
        sif.sample_in    = 16'(int'(thrsh) + $urandom_range(0, 5000) - 2500);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
